// File: rtl/wg_stream_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : wg_stream_buffer
// Ping-pong weight-row buffer: host fills the shadow bank while the active
// bank streams rows to the MAC array over valid/ready.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module wg_stream_buffer #(
  parameter int D_WL      = 24,
  parameter int UNITS_NUM = 5,
  parameter int DEPTH     = 156,
  parameter int AW        = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_en,
  input  logic [AW-1:0]             ld_addr,
  input  logic [UNITS_NUM*D_WL-1:0] ld_data,
  input  logic                      swap,
  input  logic                      start,
  input  logic [AW-1:0]             base_addr,
  input  logic [AW-1:0]             len,
  output logic [UNITS_NUM*D_WL-1:0] w_o,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic                      w_last,
  output logic                      busy,
  output logic                      done,
  output logic                      active_bank,
  output logic                      err
);

  localparam int RW = UNITS_NUM * D_WL;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [AW-1:0] DEPTH_A  = AW'(DEPTH);
  localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE_A    = AW'(1);

  logic [RW-1:0] bank0_mem [DEPTH];
  logic [RW-1:0] bank1_mem [DEPTH];

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          rd_bank;
  logic          swap_pending;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] remaining;
  logic [RW-1:0] rd_row;

  logic start_idle;
  logic start_legal;
  logic start_go;
  logic start_zero;
  logic start_bad;
  logic ld_ok;
  logic ld_bad;
  logic load;
  logic last_hs;

  assign start_idle  = start && (state == S_IDLE);
  assign start_legal = (base_addr < DEPTH_A) && (len <= DEPTH_A);
  assign start_go    = start_idle && start_legal && (len != '0);
  assign start_zero  = start_idle && start_legal && (len == '0);
  // A start seen in FIN is dropped silently; only IDLE-illegal or RUN starts flag.
  assign start_bad   = (start_idle && !start_legal) || (start && (state == S_RUN));
  assign ld_ok       = ld_en && (ld_addr < DEPTH_A);
  assign ld_bad      = ld_en && !(ld_addr < DEPTH_A);
  assign load        = (state == S_RUN) && (!w_valid || w_ready) && (remaining != '0);
  assign last_hs     = w_valid && w_ready && w_last;
  assign rd_row      = rd_bank ? bank1_mem[rd_ptr] : bank0_mem[rd_ptr];

  // Shadow-bank write uses the pre-swap bank index, so a same-cycle swap exposes it.
  always_ff @(posedge clk) begin
    if (ld_ok) begin
      if (active_bank) bank0_mem[ld_addr] <= ld_data;
      else             bank1_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_go)        state_nxt = S_RUN;
        else if (start_zero) state_nxt = S_FIN;
      end
      S_RUN:   if (last_hs) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_FIN:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank   <= 1'b0;
      rd_ptr    <= '0;
      remaining <= '0;
      w_o       <= '0;
      w_valid   <= 1'b0;
      w_last    <= 1'b0;
    end else begin
      if (start_go) begin
        rd_bank   <= swap ? ~active_bank : active_bank;
        rd_ptr    <= base_addr;
        remaining <= len;
      end else if (load) begin
        rd_ptr    <= (rd_ptr == LAST_ROW) ? '0 : rd_ptr + ONE_A;
        remaining <= remaining - ONE_A;
      end

      if (load) begin
        w_o     <= rd_row;
        w_valid <= 1'b1;
        w_last  <= (remaining == ONE_A);
      end else if (w_valid && w_ready) begin
        w_valid <= 1'b0;
        w_last  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank  <= 1'b0;
      swap_pending <= 1'b0;
      err          <= 1'b0;
    end else begin
      if ((state == S_IDLE) && swap)
        active_bank <= ~active_bank;
      else if ((state == S_FIN) && (swap_pending || swap))
        active_bank <= ~active_bank;

      if ((state == S_RUN) && swap) swap_pending <= 1'b1;
      else if (state == S_FIN)      swap_pending <= 1'b0;

      if (ld_bad || start_bad)         err <= 1'b1;
      else if (start_go || start_zero) err <= 1'b0;
    end
  end

endmodule
`default_nettype wire
